// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder.
// One fullAdder cell is shared over WIDTH clocks; operand bits are fed to it
// LSB-first, the carry is registered between cycles, and the returned sum bits
// are assembled into a parallel result.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in_start  request to begin an addition (accepted in IDLE or DONE)
//   in_a      operand A, captured on an accepted start
//   in_b      operand B, captured on an accepted start
//   in_cin    carry-in, captured on an accepted start
//   out_busy  high while an addition is in progress
//   out_done  one-cycle pulse when the result registers have just updated
//   out_sum   result of the last completed addition
//   out_cout  carry out of the MSB of the last completed addition
//   out_ovf   signed overflow of the last completed addition

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_CNT  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Holds only the upper WIDTH-1 bits of the sum shift register: the bit that
  // would fall off the bottom on the final shift is never observed.
  logic [WIDTH-2:0] r_s_sh;
  logic             r_carry;
  logic             r_msb_cin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_c;
  logic w_accept;

  fullAdder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_accept = in_start && (r_state != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_s_sh  <= (r_s_sh >> 1) | ((WIDTH-1)'(w_s) << (WIDTH - 2));
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (r_cnt == MSB_CNT) begin
        r_msb_cin <= w_c;
      end
      if (r_cnt == LAST_CNT) begin
        r_sum   <= {w_s, r_s_sh};
        r_cout  <= w_c;
        r_ovf   <= r_msb_cin ^ w_c;
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end else if (w_accept) begin
      r_a_sh  <= in_a;
      r_b_sh  <= in_b;
      r_carry <= in_cin;
      r_cnt   <= '0;
      r_s_sh  <= '0;
      r_state <= RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end
  end

  assign out_busy = r_busy;
  assign out_done = r_done;
  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk;
  logic       reset;
  logic       in_start;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       out_busy;
  logic       out_done;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       out_ovf;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_start (in_start),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] VA [4] = '{8'h5A, 8'hFF, 8'h80, 8'h7F};
  localparam logic [7:0] VB [4] = '{8'h3C, 8'h01, 8'h80, 8'h00};
  localparam logic       VC [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [9:0] VR [4] = '{{8'h96, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0},
                                    {8'h00, 1'b1, 1'b1}, {8'h80, 1'b0, 1'b1}};

  task automatic test_reset();
    reset = 1'b1; in_start = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", out_busy); end
    checks++;
    if (out_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", out_done); end
    checks++;
    if ({out_sum, out_cout, out_ovf} !== 10'h000)
      begin errors++; $display("FAIL reset_result: got %h/%b/%b want 00/0/0", out_sum, out_cout, out_ovf); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [9:0] prev;
    prev = '0;
    for (int v = 0; v < 4; v++) begin
      in_a = VA[v]; in_b = VB[v]; in_cin = VC[v]; in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0; in_a = 8'hC3; in_b = 8'h5E; in_cin = 1'b1;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_busy !== 1'b1 || out_done !== 1'b0)
          begin errors++; $display("FAIL arith%0d_run%0d busy/done: got %b/%b want 1/0", v, i, out_busy, out_done); end
        checks++;
        if ({out_sum, out_cout, out_ovf} !== prev)
          begin errors++; $display("FAIL arith%0d_hold%0d: got %h want %h", v, i, {out_sum, out_cout, out_ovf}, prev); end
        @(negedge clk);
      end
      checks++;
      if (out_done !== 1'b1 || out_busy !== 1'b0)
        begin errors++; $display("FAIL arith%0d_done: got done=%b busy=%b want 1/0", v, out_done, out_busy); end
      checks++;
      if ({out_sum, out_cout, out_ovf} !== VR[v])
        begin errors++; $display("FAIL arith%0d_result: got %h/%b/%b want %h", v, out_sum, out_cout, out_ovf, VR[v]); end
      @(negedge clk);
      checks++;
      if (out_done !== 1'b0 || out_busy !== 1'b0)
        begin errors++; $display("FAIL arith%0d_idle: got done=%b busy=%b want 0/0", v, out_done, out_busy); end
      prev = VR[v];
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    int done_at;
    dones = 0; done_at = -1;
    in_a = 8'h01; in_b = 8'h02; in_cin = 1'b0; in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (out_done === 1'b1) begin dones++; done_at = i; end
      if (i == 8) begin
        checks++;
        if (out_done !== 1'b1 || out_sum !== 8'h03)
          begin errors++; $display("FAIL ignore_result: got done=%b sum=%h want 1/03", out_done, out_sum); end
      end
      if (i == 2) begin in_start = 1'b1; in_a = 8'h11; in_b = 8'h11; end
      else in_start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || done_at != 8)
      begin errors++; $display("FAIL ignore_pulses: got %0d pulses at %0d want 1 at 8", dones, done_at); end
  endtask

  task automatic test_back_to_back();
    int n;
    int at [3];
    n = 0; at = '{-1, -1, -1};
    in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0; in_start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (out_done === 1'b1) begin
        checks++;
        if (out_sum !== 8'h30) begin errors++; $display("FAIL b2b_sum%0d: got %h want 30", n, out_sum); end
        if (n < 3) at[n] = i;
        n++;
      end
      @(negedge clk);
    end
    in_start = 1'b0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    checks++;
    if (at[0] != 8 || at[1] - at[0] != 9 || at[2] - at[1] != 9)
      begin errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want 8,17,26", at[0], at[1], at[2]); end
    for (int i = 0; i < 12 && (out_busy === 1'b1 || out_done === 1'b1); i++) @(negedge clk);
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0)
      begin errors++; $display("FAIL b2b_drain: got busy=%b done=%b want 0/0", out_busy, out_done); end
  endtask

  task automatic test_async_reset();
    int dones;
    int done_at;
    in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b0; in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_busy, out_done, out_sum, out_cout, out_ovf} !== 12'h000)
      begin errors++; $display("FAIL areset_outputs: got busy=%b done=%b %h/%b/%b want all 0",
                               out_busy, out_done, out_sum, out_cout, out_ovf); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_done === 1'b1 || out_busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL areset_no_done: got %0d active cycles want 0", dones); end
    in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0; in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    done_at = -1;
    for (int i = 0; i < 12 && done_at < 0; i++) begin
      if (out_done === 1'b1) done_at = i;
      else @(negedge clk);
    end
    checks++;
    if (done_at != 8 || out_sum !== 8'h02 || out_cout !== 1'b0 || out_ovf !== 1'b0)
      begin errors++; $display("FAIL areset_next: got done_at=%0d sum=%h/%b/%b want 8 02/0/0",
                               done_at, out_sum, out_cout, out_ovf); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
